// File: rtl/clint.sv
// CLINT: memory-mapped msip/ssip software interrupt bits plus the 64-bit mtime/mtimecmp pair.
// Each bus access takes two cycles: a request edge, then a one-cycle ack carrying registered read data.
module clint #(
    parameter int DATA_SIZE             = 32,
    parameter int CLOCK_CYCLES_PER_TICK = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 rd_en,
    input  logic                 wr_en,
    input  logic [15:0]          addr,
    input  logic [DATA_SIZE-1:0] wr_data,
    output logic [DATA_SIZE-1:0] rd_data,
    output logic                 ack,
    output logic                 mem_msip,
    output logic                 mem_ssip,
    output logic [63:0]          mem_mtime,
    output logic [63:0]          mem_mtimecmp
);

    localparam int PW = (CLOCK_CYCLES_PER_TICK > 1) ? $clog2(CLOCK_CYCLES_PER_TICK) : 1;
    localparam logic [PW-1:0] PRESCALE_MAX = PW'(CLOCK_CYCLES_PER_TICK - 1);
    localparam bit WIDE = (DATA_SIZE == 64);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_SIZE-1:0]   rd_data_q, rd_data_d;
    logic                   msip_q, msip_d;
    logic                   ssip_q, ssip_d;
    logic [63:0]            mtime_q, mtime_d;
    logic [63:0]            mtimecmp_q, mtimecmp_d;
    logic [PW-1:0]          prescaler_q, prescaler_d;
    logic                   tick;

    logic sel_msip, sel_ssip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;
    logic [DATA_SIZE-1:0] rdata;

    // The high-half registers only exist on a 32-bit bus; misaligned addresses match nothing.
    always_comb begin
        sel_msip    = (addr == 16'h0000);
        sel_ssip    = (addr == 16'h0004);
        sel_cmp_lo  = (addr == 16'h4000);
        sel_cmp_hi  = !WIDE && (addr == 16'h4004);
        sel_time_lo = (addr == 16'hBFF8);
        sel_time_hi = !WIDE && (addr == 16'hBFFC);
    end

    always_comb begin
        rdata = '0;
        if (sel_msip)    rdata = DATA_SIZE'(msip_q);
        if (sel_ssip)    rdata = DATA_SIZE'(ssip_q);
        if (sel_cmp_lo)  rdata = mtimecmp_q[DATA_SIZE-1:0];
        if (sel_cmp_hi)  rdata = DATA_SIZE'(mtimecmp_q[63:32]);
        if (sel_time_lo) rdata = mtime_q[DATA_SIZE-1:0];
        if (sel_time_hi) rdata = DATA_SIZE'(mtime_q[63:32]);
    end

    always_comb begin
        state_d      = state_q;
        rd_data_d    = '0;
        msip_d       = msip_q;
        ssip_d       = ssip_q;
        mtimecmp_d   = mtimecmp_q;
        tick         = (prescaler_q == PRESCALE_MAX);
        prescaler_d  = tick ? '0 : prescaler_q + PW'(1);
        mtime_d      = tick ? mtime_q + 64'd1 : mtime_q;

        case (state_q)
            IDLE: begin
                if (rd_en || wr_en) begin
                    state_d = ACK;
                    if (wr_en) begin
                        if (sel_msip) msip_d = wr_data[0];
                        if (sel_ssip) ssip_d = wr_data[0];
                        if (sel_cmp_lo) begin
                            if (WIDE) mtimecmp_d = 64'(wr_data);
                            else      mtimecmp_d = {mtimecmp_q[63:32], wr_data[31:0]};
                        end
                        if (sel_cmp_hi) mtimecmp_d = {wr_data[31:0], mtimecmp_q[31:0]};
                        // A bus write to mtime overrides the tick; the untouched half keeps its old value.
                        if (sel_time_lo) begin
                            if (WIDE) mtime_d = 64'(wr_data);
                            else      mtime_d = {mtime_q[63:32], wr_data[31:0]};
                        end
                        if (sel_time_hi) mtime_d = {wr_data[31:0], mtime_q[31:0]};
                    end else begin
                        rd_data_d = rdata;
                    end
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= IDLE;
            rd_data_q   <= '0;
            msip_q      <= 1'b0;
            ssip_q      <= 1'b0;
            mtime_q     <= '0;
            mtimecmp_q  <= '1;
            prescaler_q <= '0;
        end else begin
            state_q     <= state_d;
            rd_data_q   <= rd_data_d;
            msip_q      <= msip_d;
            ssip_q      <= ssip_d;
            mtime_q     <= mtime_d;
            mtimecmp_q  <= mtimecmp_d;
            prescaler_q <= prescaler_d;
        end
    end

    assign ack          = (state_q == ACK);
    assign rd_data      = rd_data_q;
    assign mem_msip     = msip_q;
    assign mem_ssip     = ssip_q;
    assign mem_mtime    = mtime_q;
    assign mem_mtimecmp = mtimecmp_q;

endmodule
